mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-to-one memory port arbiter for the instruction and data caches.
// Handles round-robin request grant, write-data bursts and in-order read-response routing.
module mem_arbiter #(
  parameter int unsigned ADDR_BITS       = 28,
  parameter int unsigned DATA_BITS       = 128,
  parameter int unsigned BEATS           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     ic_mem_req_val,
  output logic                     ic_mem_req_rdy,
  input  logic [ADDR_BITS-1:0]     ic_mem_req_addr,
  input  logic                     ic_mem_req_rw,
  input  logic                     ic_mem_req_data_valid,
  output logic                     ic_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]     ic_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0]   ic_mem_req_data_mask,
  output logic                     ic_mem_resp_val,
  output logic [DATA_BITS-1:0]     ic_mem_resp_data,

  input  logic                     dc_mem_req_val,
  output logic                     dc_mem_req_rdy,
  input  logic [ADDR_BITS-1:0]     dc_mem_req_addr,
  input  logic                     dc_mem_req_rw,
  input  logic                     dc_mem_req_data_valid,
  output logic                     dc_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]     dc_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0]   dc_mem_req_data_mask,
  output logic                     dc_mem_resp_val,
  output logic [DATA_BITS-1:0]     dc_mem_resp_data,

  output logic                     mem_req_val,
  input  logic                     mem_req_rdy,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [DATA_BITS-1:0]     mem_req_data_bits,
  output logic [DATA_BITS/8-1:0]   mem_req_data_mask,
  input  logic                     mem_resp_val,
  input  logic [DATA_BITS-1:0]     mem_resp_data,
  output logic                     resp_err
);

  localparam int unsigned MASK_BITS = DATA_BITS / 8;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OCC_W     = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(MAX_OUTSTANDING);

  typedef enum logic {
    S_IDLE,
    S_WDATA
  } state_t;

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic [CNT_W-1:0]         wcnt_q, wcnt_d;
  logic [CNT_W-1:0]         rcnt_q;
  logic                     lock_q, lock_port_q;
  logic                     rr_last_q;
  logic                     resp_err_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PTR_W-1:0]         rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]         occ_q;

  logic                     fifo_full, fifo_empty;
  logic                     ic_elig, dc_elig, gnt;
  logic                     req_val, req_rw, req_fire;
  logic [ADDR_BITS-1:0]     req_addr;
  logic                     wd_active, wd_valid, wbeat;
  logic [DATA_BITS-1:0]     wd_bits;
  logic [MASK_BITS-1:0]     wd_mask;
  logic                     head, resp_hit, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy is the registered count, so a same-cycle pop never frees a slot early.
  assign fifo_full  = (occ_q == FULL_OCC);
  assign fifo_empty = (occ_q == '0);

  // Grant selection: held lock, then sole eligible port, then round-robin.
  always_comb begin
    ic_elig = ic_mem_req_val & (ic_mem_req_rw | ~fifo_full);
    dc_elig = dc_mem_req_val & (dc_mem_req_rw | ~fifo_full);
    if (lock_q)                gnt = lock_port_q;
    else if (ic_elig && !dc_elig) gnt = 1'b0;
    else if (dc_elig && !ic_elig) gnt = 1'b1;
    else                       gnt = ~rr_last_q;
  end

  assign req_val  = (state_q == S_IDLE) & (gnt ? dc_elig : ic_elig);
  assign req_rw   = gnt ? dc_mem_req_rw   : ic_mem_req_rw;
  assign req_addr = gnt ? dc_mem_req_addr : ic_mem_req_addr;
  assign req_fire = req_val & mem_req_rdy;

  assign wd_active = (state_q == S_WDATA);
  assign wd_valid  = wd_active & (owner_q ? dc_mem_req_data_valid : ic_mem_req_data_valid);
  assign wd_bits   = owner_q ? dc_mem_req_data_bits : ic_mem_req_data_bits;
  assign wd_mask   = owner_q ? dc_mem_req_data_mask : ic_mem_req_data_mask;
  assign wbeat     = wd_valid & mem_req_data_ready;

  assign head     = fifo_q[rd_ptr_q];
  assign resp_hit = mem_resp_val & ~fifo_empty;
  assign push     = req_fire & ~req_rw;
  assign pop      = resp_hit & (rcnt_q == LAST_BEAT);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // FSM next state: write fire opens a data burst owned by the granted port
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire && req_rw) begin
          state_d = S_WDATA;
          owner_d = gnt;
          wcnt_d  = '0;
        end
      end
      S_WDATA: begin
        if (wbeat) begin
          if (wcnt_q == LAST_BEAT) state_d = S_IDLE;
          else                     wcnt_d  = wcnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant lock, round-robin history, owner FIFO and response beat tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q      <= 1'b0;
      lock_port_q <= 1'b0;
      rr_last_q   <= 1'b1;
      fifo_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      rcnt_q      <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      lock_q      <= req_val & ~mem_req_rdy;
      lock_port_q <= gnt;
      if (req_fire) rr_last_q <= gnt;
      if (push) begin
        fifo_q[wr_ptr_q] <= gnt;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (resp_hit) rcnt_q <= (rcnt_q == LAST_BEAT) ? '0 : rcnt_q + CNT_W'(1);
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
      if (mem_resp_val && fifo_empty) resp_err_q <= 1'b1;
    end
  end

  // Outputs forced low while reset is asserted
  assign mem_req_val        = reset & req_val;
  assign mem_req_addr       = reset ? req_addr : '0;
  assign mem_req_rw         = reset & req_rw;
  assign ic_mem_req_rdy     = reset & req_val & ~gnt & mem_req_rdy;
  assign dc_mem_req_rdy     = reset & req_val &  gnt & mem_req_rdy;

  assign mem_req_data_valid    = reset & wd_valid;
  assign mem_req_data_bits     = (reset && wd_active) ? wd_bits : '0;
  assign mem_req_data_mask     = (reset && wd_active) ? wd_mask : '0;
  assign ic_mem_req_data_ready = reset & wd_active & ~owner_q & mem_req_data_ready;
  assign dc_mem_req_data_ready = reset & wd_active &  owner_q & mem_req_data_ready;

  assign ic_mem_resp_val  = reset & resp_hit & ~head;
  assign dc_mem_resp_val  = reset & resp_hit &  head;
  assign ic_mem_resp_data = reset ? mem_resp_data : '0;
  assign dc_mem_resp_data = reset ? mem_resp_data : '0;
  assign resp_err         = resp_err_q;

endmodule
